// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin writeback arbiter feeding the single register-file write port
//
// Optional feature macro: WB_ARB_FWD_EN (adds decode bypass ports fwd_sr1/fwd_sr2/fwd_hit_one/fwd_hit_two/fwd_data)
//
// Ports:
//   CLK        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   req_valid  in   [NUM_REQ]        requester i has a write pending
//   req_dr     in   [NUM_REQ*RA_W]   destination register, requester 0 at the LSBs
//   req_data   in   [NUM_REQ*XLEN]   write data, requester 0 at the LSBs
//   req_ready  out  [NUM_REQ]        one-hot grant (transfer = valid & ready)
//   wb_stall   in   freeze grants and hold the output stage
//   DR         out  [RA_W]           registered destination register
//   WB_DATA    out  [XLEN]           registered write data
//   ST_REG     out  registered write enable, masked while stalled or in reset
//   grant_id   out  [IDX_W]          requester that produced the current output stage
//   fwd_sr1/2  in   [RA_W]           decode source registers (WB_ARB_FWD_EN)
//   fwd_hit_*  out  live output-stage write matches the source (WB_ARB_FWD_EN)
//   fwd_data   out  [XLEN]           output-stage data for bypass (WB_ARB_FWD_EN)

module wb_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 64,
  parameter int RA_W    = 5,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*RA_W-1:0]  req_dr,
  input  logic [NUM_REQ*XLEN-1:0]  req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     wb_stall,
  output logic [RA_W-1:0]          DR,
  output logic [XLEN-1:0]          WB_DATA,
  output logic                     ST_REG,
  output logic [IDX_W-1:0]         grant_id
`ifdef WB_ARB_FWD_EN
  ,
  input  logic [RA_W-1:0]          fwd_sr1,
  input  logic [RA_W-1:0]          fwd_sr2,
  output logic                     fwd_hit_one,
  output logic                     fwd_hit_two,
  output logic [XLEN-1:0]          fwd_data
`endif
);

  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] rr_ptr;
  logic             st_q;

  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W:0]   cand;
  logic [RA_W-1:0]  sel_dr;
  logic [XLEN-1:0]  sel_data;
  logic [IDX_W-1:0] rr_next;

  // Rotating priority search: first valid requester at or after rr_ptr.
  // cand carries one extra bit so rr_ptr + k never overflows before the
  // modulo correction.
  always_comb begin
    req_ready   = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (!reset && !wb_stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
        if (cand >= NUM_REQ_W) begin
          cand = cand - NUM_REQ_W;
        end
        if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
          grant_found = 1'b1;
          grant_idx   = cand[IDX_W-1:0];
        end
      end
      req_ready[grant_idx] = grant_found;
    end
  end

  // Payload mux with constant slice offsets after unrolling.
  always_comb begin
    sel_dr   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_dr   = req_dr[i*RA_W +: RA_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign rr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  // The stall leaves every register untouched so a pending write in the
  // output stage survives and is issued once the stall drops.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rr_ptr   <= '0;
      st_q     <= 1'b0;
      DR       <= '0;
      WB_DATA  <= '0;
      grant_id <= '0;
    end else if (!wb_stall) begin
      if (grant_found) begin
        rr_ptr   <= rr_next;
        DR       <= sel_dr;
        WB_DATA  <= sel_data;
        grant_id <= grant_idx;
        // x0 writes are consumed from the requester but never enabled.
        st_q     <= |sel_dr;
      end else begin
        st_q     <= 1'b0;
      end
    end
  end

  // Masking with reset keeps a write that is being discarded off the port.
  assign ST_REG = st_q & ~wb_stall & ~reset;

`ifdef WB_ARB_FWD_EN
  // Bypass uses the stored flag: a stalled but still pending write is live.
  assign fwd_hit_one = st_q && (DR == fwd_sr1) && (DR != '0);
  assign fwd_hit_two = st_q && (DR == fwd_sr2) && (DR != '0);
  assign fwd_data    = WB_DATA;
`endif

endmodule
